neuron_mac_stream: RTL and testbench



---
 rtl/neuron_pkg.sv | 34 +++
 rtl/neuron_lane_dot.sv | 32 +++
 rtl/neuron_mac_stream.sv | 144 ++++++++++++++
 tb/tb_neuron_mac_stream.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types, default widths and helper functions for the streaming MAC neuron.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_OUTPUT
  } state_e;

  localparam int unsigned DEF_IN_SIZE  = 196;
  localparam int unsigned DEF_LANES    = 4;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_WEIGHT_W = 8;
  localparam int unsigned DEF_ACC_W    = 40;
  localparam int unsigned DEF_OUT_W    = 32;

  function automatic int unsigned beat_cnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Clamp a signed value into the signed range of a w-bit result (w <= 63).
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/neuron_lane_dot.sv
// Combinational LANES-wide signed dot product, sign-extended to ACC_W.
module neuron_lane_dot #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned ACC_W    = 40
) (
  input  logic        [LANES*DATA_W-1:0]   data_i,
  input  logic        [LANES*WEIGHT_W-1:0] weight_i,
  output logic signed [ACC_W-1:0]          sum_o
);

  localparam int unsigned PW = DATA_W + WEIGHT_W;

  logic signed [ACC_W-1:0] sum_d;

  always_comb begin
    logic signed [DATA_W-1:0]   a;
    logic signed [WEIGHT_W-1:0] b;
    logic signed [PW-1:0]       prod;
    sum_d = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      a     = data_i[l*DATA_W +: DATA_W];
      b     = weight_i[l*WEIGHT_W +: WEIGHT_W];
      prod  = PW'(a) * PW'(b);
      sum_d = sum_d + ACC_W'(prod);
    end
  end

  assign sum_o = sum_d;

endmodule

// File: rtl/neuron_mac_stream.sv
// Streaming multi-lane MAC neuron: accumulate IN_SIZE products, add bias, saturate.
// Optional ReLU after saturation is enabled with the NEURON_RELU_EN macro.
module neuron_mac_stream
  import neuron_pkg::*;
#(
  parameter int unsigned IN_SIZE  = DEF_IN_SIZE,
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned OUT_W    = DEF_OUT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WEIGHT_W-1:0]       bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*WEIGHT_W-1:0] in_weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      busy
);

  localparam int unsigned BEATS = IN_SIZE / LANES;
  localparam int unsigned CNT_W = beat_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((IN_SIZE % LANES) != 0) begin : g_chk_lanes
    $error("IN_SIZE must be a multiple of LANES");
  end
  if (ACC_W < DATA_W + WEIGHT_W + $clog2(IN_SIZE)) begin : g_chk_acc
    $error("ACC_W too narrow for IN_SIZE products");
  end
  if (ACC_W > 63 || OUT_W > 63) begin : g_chk_max
    $error("ACC_W and OUT_W must not exceed 63");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic                    drain_q, drain_d;
  logic signed [WEIGHT_W-1:0] bias_q;
  logic signed [ACC_W-1:0] lane_sum, lane_sum_q, acc_q;
  logic                    lane_vld_q;
  logic [OUT_W-1:0]        out_data_q;
  logic                    beat_acc;
  logic signed [63:0]      total, sat_val;
  logic [OUT_W-1:0]        result;

  neuron_lane_dot #(
    .LANES   (LANES),
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .ACC_W   (ACC_W)
  ) u_dot (
    .data_i  (in_data),
    .weight_i(in_weight),
    .sum_o   (lane_sum)
  );

  assign beat_acc  = (state_q == ST_ACCUM) && in_valid;
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUTPUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // DRAIN is two cycles: drain_q marks the second, on which stage 3 fires.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          beat_d  = '0;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign total = $signed({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q})
               + $signed({{(64-WEIGHT_W){bias_q[WEIGHT_W-1]}}, bias_q});

  always_comb begin
    sat_val = sat_to_width(total, OUT_W);
`ifdef NEURON_RELU_EN
    if (sat_val < 0) sat_val = '0;
`endif
    result = sat_val[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q     <= '0;
      lane_sum_q <= '0;
      lane_vld_q <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      lane_vld_q <= beat_acc;
      if (beat_acc) lane_sum_q <= lane_sum;
      if (state_q == ST_IDLE && start) begin
        bias_q <= bias;
        acc_q  <= '0;
      end else if (lane_vld_q) begin
        acc_q <= acc_q + lane_sum_q;
      end
      if (state_q == ST_DRAIN && drain_q) out_data_q <= result;
    end
  end

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Directed, table-driven bench for neuron_mac_stream (IN_SIZE=8, LANES=4, OUT_W=16).
module tb_neuron_mac_stream;

  localparam int IN_SIZE  = 8;
  localparam int LANES    = 4;
  localparam int DATA_W   = 16;
  localparam int WEIGHT_W = 8;
  localparam int ACC_W    = 40;
  localparam int OUT_W    = 16;
  localparam int BEATS    = IN_SIZE / LANES;
  localparam int NV       = 8;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    int d[IN_SIZE];
    int w[IN_SIZE];
    int b;
    int exp;
    int gap;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready;
  logic [WEIGHT_W-1:0]       bias;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [LANES*WEIGHT_W-1:0] in_weight;
  logic                      in_ready, out_valid, busy;
  logic [OUT_W-1:0]          out_data;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  neuron_mac_stream #(
    .IN_SIZE (IN_SIZE),
    .LANES   (LANES),
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_weight(in_weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input int idx, input int b);
    for (int l = 0; l < LANES; l++) begin
      in_data[l*DATA_W +: DATA_W]       = DATA_W'(vecs[idx].d[b*LANES+l]);
      in_weight[l*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(vecs[idx].w[b*LANES+l]);
    end
    in_valid = 1'b1;
  endtask

  task automatic run_vec(input int idx, input bit hold);
    int lat;
    @(negedge clk);
    start = 1'b1;
    bias  = WEIGHT_W'(vecs[idx].b);
    @(negedge clk);
    start = 1'b0;
    bias  = 8'h55;
    check($sformatf("v%0d_busy_after_start", idx), int'(busy), 1);
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0 && vecs[idx].gap > 0) begin
        in_valid = 1'b0;
        repeat (vecs[idx].gap) begin
          @(negedge clk);
          check($sformatf("v%0d_ready_in_gap", idx), int'(in_ready), 1);
        end
      end
      send_beat(idx, b);
      check($sformatf("v%0d_ready_beat%0d", idx, b), int'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check($sformatf("v%0d_ready_after_last", idx), int'(in_ready), 0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, 3);
    check($sformatf("v%0d_out_data", idx), int'($signed(out_data)), vecs[idx].exp);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        start = (i % 2 == 0);
        @(negedge clk);
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_out_data", int'($signed(out_data)), vecs[idx].exp);
        check("hold_busy", int'(busy), 1);
      end
      start = 1'b1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d_valid_after_accept", idx), int'(out_valid), 0);
    check($sformatf("v%0d_idle_after_accept", idx), int'(busy), 0);
    if (hold) begin
      @(negedge clk);
      start = 1'b0;
      check("start_after_accept", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_from_accum", int'(busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{'{1, 2, 3, 4, 5, 6, 7, 8}, '{1, 1, 1, 1, 2, 2, 2, 2}, 3, 65, 0};
    vecs[1] = '{'{1, 2, 3, 4, 5, 6, 7, 8}, '{1, 1, 1, 1, 2, 2, 2, 2}, 3, 65, 5};
    vecs[2] = '{'{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767},
                '{127, 127, 127, 127, 127, 127, 127, 127}, 127, 32767, 0};
    vecs[3] = '{'{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767},
                '{-128, -128, -128, -128, -128, -128, -128, -128}, 127,
                (RELU ? 0 : -32768), 0};
    vecs[4] = '{'{-1, -2, -3, -4, 1, 1, 1, 1}, '{1, 1, 1, 1, -1, -1, -1, -1}, -6,
                (RELU ? 0 : -20), 0};
    vecs[5] = '{'{32767, 1, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0}, -1, 32767, 0};
    vecs[6] = '{'{100, -200, 300, -400, 1000, 2000, -3000, 50},
                '{3, -2, 1, -1, 5, 5, -7, -128}, 100, 31100, 0};
    vecs[7] = '{'{16384, 16384, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0}, 0, 32767, 0};

    reset     = 1'b1;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_weight = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'($signed(out_data)), 0);

    for (int v = 0; v < NV; v++) run_vec(v, 1'b0);

    // Backpressure with ignored start pulses, then a start right after acceptance.
    run_vec(0, 1'b1);

    // Abort after one of two beats, using large values that would corrupt a later result.
    @(negedge clk);
    start = 1'b1;
    bias  = 8'd50;
    @(negedge clk);
    start = 1'b0;
    send_beat(2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    repeat (3) @(negedge clk);
    check("abort_no_output", int'(out_valid), 0);
    run_vec(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
